// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} arb_state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;

   localparam int unsigned STARVE_CNT_W = 4;
   // Instruction fetch always reads a full 32-bit word.
   localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the unified memory arbiter.
// master is the arbiter's view; slave is the core/memory environment's view.
interface unified_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_WIDTH-1:0] if_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [2:0]            d_funct3;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_WIDTH-1:0] d_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [2:0]            mem_funct3;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  protocol_err;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rvalid, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, protocol_err
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rvalid, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, protocol_err
   );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of acceptance slots in which a pending fetch lost to data.
module arb_starve_ctr
   import mem_arb_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    inc_i,
   input  logic                    clr_i,
   input  logic [STARVE_CNT_W-1:0] limit_i,
   output logic                    at_limit_o
);

   logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < limit_i)) begin
         cnt_d = cnt_q + STARVE_CNT_W'(1);
      end
      at_limit_o = (cnt_q == limit_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction
// outstanding at a time, with a starvation guard that keeps fetch moving.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   unified_mem_arbiter_if.master   bus
);

   arb_state_t state_q, state_d;
   logic       err_q, err_d;
   logic       slot, if_win, d_win, at_limit, starve_inc, starve_clr;
   owner_t     owner;

   arb_starve_ctr u_starve (
      .clk_i      (clk),
      .rst_ni     (rst),
      .inc_i      (starve_inc),
      .clr_i      (starve_clr),
      .limit_i    (STARVE_CNT_W'(STARVE_LIMIT)),
      .at_limit_o (at_limit)
   );

   // A response retiring this cycle frees the port, allowing back-to-back issue.
   always_comb begin
      slot       = (state_q == IDLE) || bus.mem_rvalid;
      if_win     = slot && bus.if_req && (at_limit || !bus.d_req);
      d_win      = slot && bus.d_req && !if_win;
      owner      = if_win ? OWN_IF : OWN_D;
      starve_inc = bus.if_req && d_win;
      starve_clr = if_win || !bus.if_req;

      state_d = state_q;
      if (if_win) begin
         state_d = BUSY_IF;
      end else if (d_win) begin
         state_d = BUSY_D;
      end else if (slot) begin
         state_d = IDLE;
      end

      err_d = err_q || ((state_q == IDLE) && bus.mem_rvalid);
   end

   always_comb begin
      bus.if_gnt       = 1'b0;
      bus.d_gnt        = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_funct3   = '0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      bus.if_rvalid    = 1'b0;
      bus.if_rdata     = '0;
      bus.d_rvalid     = 1'b0;
      bus.d_rdata      = '0;
      bus.protocol_err = 1'b0;

      // Everything is held low while reset is asserted, grants included.
      if (rst) begin
         bus.protocol_err = err_q;
         if (if_win || d_win) begin
            bus.mem_req = 1'b1;
            unique case (owner)
               OWN_IF: begin
                  bus.if_gnt     = 1'b1;
                  bus.mem_funct3 = FUNCT3_WORD;
                  bus.mem_addr   = bus.if_addr;
               end
               OWN_D: begin
                  bus.d_gnt      = 1'b1;
                  bus.mem_we     = bus.d_we;
                  bus.mem_funct3 = bus.d_funct3;
                  bus.mem_addr   = bus.d_addr;
                  bus.mem_wdata  = bus.d_wdata;
               end
               default: ;
            endcase
         end
         if (bus.mem_rvalid) begin
            unique case (state_q)
               BUSY_IF: begin
                  bus.if_rvalid = 1'b1;
                  bus.if_rdata  = bus.mem_rdata;
               end
               BUSY_D: begin
                  bus.d_rvalid = 1'b1;
                  bus.d_rdata  = bus.mem_rdata;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model (owner of the outstanding access, fetch loss count).
module tb_unified_mem_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   unified_mem_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    n_checks = 0;
   int    n_pass   = 0;
   string phase    = "init";

   // Model: who owns the outstanding access (0 none, 1 fetch, 2 data),
   // how many slots in a row a waiting fetch has lost, and the sticky error.
   int    m_owner  = 0;
   int    m_losses = 0;
   bit    m_err    = 1'b0;
   bit    m_slot;
   bit    e_if_gnt, e_d_gnt, e_mem_req;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic settle();
      logic [2:0]  e_f3;
      logic [31:0] e_addr, e_wdata;
      bit          e_if_rv, e_d_rv;
      #4;
      m_slot    = (m_owner == 0) || bus.mem_rvalid;
      e_if_gnt  = rst && m_slot && bus.if_req && ((m_losses >= int'(LIMIT)) || !bus.d_req);
      e_d_gnt   = rst && m_slot && bus.d_req && !e_if_gnt;
      e_mem_req = e_if_gnt || e_d_gnt;
      e_f3      = e_d_gnt ? bus.d_funct3 : (e_if_gnt ? 3'b010 : 3'b000);
      e_addr    = e_d_gnt ? bus.d_addr : (e_if_gnt ? bus.if_addr : 32'h0);
      e_wdata   = e_d_gnt ? bus.d_wdata : 32'h0;
      e_if_rv   = rst && (m_owner == 1) && bus.mem_rvalid;
      e_d_rv    = rst && (m_owner == 2) && bus.mem_rvalid;
      check_eq($sformatf("%s.if_gnt", phase), 32'(bus.if_gnt), 32'(e_if_gnt));
      check_eq($sformatf("%s.d_gnt", phase), 32'(bus.d_gnt), 32'(e_d_gnt));
      check_eq($sformatf("%s.mem_req", phase), 32'(bus.mem_req), 32'(e_mem_req));
      check_eq($sformatf("%s.mem_we", phase), 32'(bus.mem_we), 32'(e_d_gnt && bus.d_we));
      check_eq($sformatf("%s.mem_funct3", phase), 32'(bus.mem_funct3), 32'(e_f3));
      check_eq($sformatf("%s.mem_addr", phase), bus.mem_addr, e_addr);
      check_eq($sformatf("%s.mem_wdata", phase), bus.mem_wdata, e_wdata);
      check_eq($sformatf("%s.if_rvalid", phase), 32'(bus.if_rvalid), 32'(e_if_rv));
      check_eq($sformatf("%s.if_rdata", phase), bus.if_rdata, e_if_rv ? bus.mem_rdata : 32'h0);
      check_eq($sformatf("%s.d_rvalid", phase), 32'(bus.d_rvalid), 32'(e_d_rv));
      check_eq($sformatf("%s.d_rdata", phase), bus.d_rdata, e_d_rv ? bus.mem_rdata : 32'h0);
      check_eq($sformatf("%s.protocol_err", phase), 32'(bus.protocol_err), 32'(rst && m_err));
   endtask

   task automatic advance();
      @(posedge clk);
      if (!rst) begin
         m_owner  = 0;
         m_losses = 0;
         m_err    = 1'b0;
      end else begin
         if ((m_owner == 0) && bus.mem_rvalid) m_err = 1'b1;
         if (e_if_gnt || !bus.if_req) m_losses = 0;
         else if (e_d_gnt && (m_losses < int'(LIMIT))) m_losses++;
         if (e_if_gnt) m_owner = 1;
         else if (e_d_gnt) m_owner = 2;
         else if (m_slot) m_owner = 0;
      end
      #1;
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   initial begin
      bit          pend;
      int          rem;
      bit          rv;
      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.d_req      = 1'b0;
      bus.d_we       = 1'b0;
      bus.d_funct3   = '0;
      bus.d_addr     = '0;
      bus.d_wdata    = '0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;

      phase = "reset";
      cycle();
      rst = 1'b1;
      settle();
      check_eq("reset.err_clear", 32'(bus.protocol_err), 32'd0);
      advance();

      // Solo fetch, memory latency 2.
      phase = "solo";
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      settle();
      check_eq("solo.gnt_c0", 32'(bus.if_gnt), 32'd1);
      advance();
      bus.if_req = 1'b0;
      cycle();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0050_0093;
      settle();
      check_eq("solo.rvalid_c2", 32'(bus.if_rvalid), 32'd1);
      check_eq("solo.rdata_c2", bus.if_rdata, 32'h0050_0093);
      advance();
      bus.mem_rvalid = 1'b0;

      // Both ports requesting continuously against a latency-1 memory.
      phase = "contend";
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.d_req  = 1'b1; bus.d_addr  = 32'h200; bus.d_funct3 = 3'b010;
      for (int k = 0; k < 15; k++) begin
         bus.mem_rvalid = (k != 0);
         bus.mem_rdata  = $urandom();
         settle();
         check_eq("contend.if_turn", 32'(bus.if_gnt), 32'((k % 5) == 4));
         check_eq("contend.addr", bus.mem_addr, ((k % 5) == 4) ? 32'h40 : 32'h200);
         advance();
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      cycle();
      bus.mem_rvalid = 1'b0;

      // Store, acknowledged one cycle later while fetch takes the freed slot.
      phase = "store";
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1_0000;
      bus.d_wdata = 32'hDEAD_BEEF; bus.d_funct3 = 3'b010;
      settle();
      check_eq("store.mem_we", 32'(bus.mem_we), 32'd1);
      check_eq("store.mem_addr", bus.mem_addr, 32'h1_0000);
      check_eq("store.mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      advance();
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      settle();
      check_eq("b2b.d_rvalid", 32'(bus.d_rvalid), 32'd1);
      check_eq("b2b.d_rdata", bus.d_rdata, 32'h0);
      check_eq("b2b.if_gnt", 32'(bus.if_gnt), 32'd1);
      advance();
      bus.if_req = 1'b0; bus.mem_rdata = 32'hCAFE_F00D;
      settle();
      check_eq("b2b.busy_if", 32'(bus.if_rvalid), 32'd1);
      advance();
      bus.mem_rvalid = 1'b0;

      phase = "spurious";
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
      cycle();
      bus.mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check_eq("spurious.err_sticky", 32'(bus.protocol_err), 32'd1);
         advance();
      end

      // Reset while a load is outstanding; its late response is spurious.
      phase = "rstmid";
      bus.d_req = 1'b1; bus.d_addr = 32'h100; bus.d_funct3 = 3'b010;
      settle();
      check_eq("rstmid.d_gnt", 32'(bus.d_gnt), 32'd1);
      advance();
      bus.if_req = 1'b1;
      rst = 1'b0;
      settle();
      check_eq("rstmid.gnt_in_reset", 32'(bus.if_gnt | bus.d_gnt), 32'd0);
      advance();
      rst = 1'b1;
      bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_rvalid = 1'b1;
      settle();
      check_eq("rstmid.no_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      advance();
      bus.mem_rvalid = 1'b0;
      settle();
      check_eq("rstmid.err_set", 32'(bus.protocol_err), 32'd1);
      advance();

      phase = "clear";
      rst = 1'b0;
      cycle();
      rst = 1'b1;

      // Random traffic with a memory of latency 1..3.
      phase = "random";
      pend = 1'b0;
      rem  = 0;
      for (int n = 0; n < 400; n++) begin
         rv = pend && (rem == 0);
         bus.mem_rvalid = rv;
         bus.mem_rdata  = $urandom();
         if (!bus.if_req && ($urandom_range(2) == 0)) begin
            bus.if_req  = 1'b1;
            bus.if_addr = $urandom() & 32'hFFFF_FFFC;
         end
         if (!bus.d_req && ($urandom_range(1) == 0)) begin
            bus.d_req    = 1'b1;
            bus.d_we     = 1'($urandom_range(1));
            bus.d_funct3 = 3'($urandom_range(7));
            bus.d_addr   = $urandom();
            bus.d_wdata  = $urandom();
         end
         cycle();
         if (e_if_gnt) bus.if_req = 1'b0;
         if (e_d_gnt) bus.d_req = 1'b0;
         if (rv) pend = 1'b0;
         if (e_mem_req) begin
            pend = 1'b1;
            rem  = $urandom_range(3, 1);
         end
         if (pend) rem--;
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      bus.mem_rvalid = pend;
      cycle();
      bus.mem_rvalid = 1'b0;
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
